mem_ctr_burst: RTL and testbench

Parametrised, cycle-timed successor to the bus-2 memory controller: a line-addressed backing store for the cache side of the system. It adds a configurable line/beat geometry, a fixed access latency, valid/ready command and write-data handshakes, and a deterministic pseudo-random fill that runs after every reset release. The block sits behind the cache as the only owner of main-memory contents.

---
 rtl/mem_ctr_burst.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mem_ctr_burst.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctr_burst.sv
// -----------------------------------------------------------------------------
// mem_ctr_burst
//
// Line-addressed backing store that sits behind the cache. It is the only
// owner of main-memory contents. Each access moves a whole line as BEATS
// narrow beats, with a fixed access latency. After every reset release the
// whole store is refilled with a deterministic pseudo-random pattern, one
// byte per cycle.
//
// Parameters
//   ADDR_W      line-address width, depth = 2**ADDR_W lines
//   LINE_BYTES  bytes per line
//   BUS_BYTES   bytes per data beat, BEATS = LINE_BYTES / BUS_BYTES
//   LATENCY     access latency in cycles (>= 1)
//   SEED        nonzero seed of the 32-bit fill LFSR
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_cmd_valid    command offered
//   o_cmd_ready    command accepted when high together with i_cmd_valid
//   i_cmd_write    1 = write line, 0 = read line
//   i_cmd_addr     line address
//   i_wdata_valid  write beat offered
//   o_wdata_ready  write beat accepted
//   i_wdata        write beat, lowest line byte in bits [7:0]
//   o_rdata_valid  read beat valid, no backpressure
//   o_rdata        read beat, zero whenever o_rdata_valid is low
//   o_rdata_last   final beat of a line
//   o_wr_done      one-cycle pulse when a write line is committed
//   o_init_done    fill complete, stays high until the next reset
// -----------------------------------------------------------------------------
module mem_ctr_burst #(
  parameter int          ADDR_W     = 10,
  parameter int          LINE_BYTES = 16,
  parameter int          BUS_BYTES  = 2,
  parameter int          LATENCY    = 100,
  parameter logic [31:0] SEED       = 32'd225526
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_write,
  input  logic [ADDR_W-1:0]      i_cmd_addr,
  input  logic                   i_wdata_valid,
  output logic                   o_wdata_ready,
  input  logic [BUS_BYTES*8-1:0] i_wdata,
  output logic                   o_rdata_valid,
  output logic [BUS_BYTES*8-1:0] o_rdata,
  output logic                   o_rdata_last,
  output logic                   o_wr_done,
  output logic                   o_init_done
);

  localparam int BEATS     = LINE_BYTES / BUS_BYTES;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int BUS_BITS  = BUS_BYTES * 8;
  localparam int BYTE_W    = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W     = $clog2(LATENCY + 1);

  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(LINE_BYTES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = '1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_WAIT,
    ST_RD_WAIT,
    ST_RD_DATA
  } state_t;

  state_t               r_state;
  state_t               w_nextState;

  // Main storage. It is deliberately not reset: the fill pass rewrites
  // every byte after each reset release.
  logic [LINE_BITS-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0]    r_addr;
  logic [CNT_W-1:0]     r_cnt;
  logic [BEAT_W-1:0]    r_beat;
  logic [ADDR_W-1:0]    r_initLine;
  logic [BYTE_W-1:0]    r_initByte;
  logic [31:0]          r_lfsr;
  logic [LINE_BITS-1:0] r_wbuf;
  logic                 r_wrDone;
  logic                 r_initDone;

  logic                 w_cmdFire;
  logic                 w_beatFire;
  logic                 w_lastBeatIn;
  logic                 w_initLast;
  logic                 w_cntZero;
  logic                 w_commit;
  logic [31:0]          w_lfsrNext;
  logic [LINE_BITS-1:0] w_readLine;

  // Handshakes and the fill/latency bookkeeping that the FSM steers on.
  // The commit strobe fires exactly once per write: on the first WR_WAIT
  // cycle whose counter has drained, while r_wrDone is still low.
  assign w_cmdFire    = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_beatFire   = (r_state == ST_WR_DATA) && i_wdata_valid;
  assign w_lastBeatIn = w_beatFire && (r_beat == LAST_BEAT);
  assign w_initLast   = (r_state == ST_INIT) && (r_initLine == LAST_LINE) &&
                        (r_initByte == LAST_BYTE);
  assign w_cntZero    = (r_cnt == '0);
  assign w_commit     = (r_state == ST_WR_WAIT) && w_cntZero && !r_wrDone;

  // Galois LFSR, shifting right; the bit shifted out selects the tap XOR.
  assign w_lfsrNext   = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);

  assign w_readLine   = r_mem[r_addr];

  // State register. Reset drops straight back into the fill pass, which
  // aborts whatever transaction was in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. WR_WAIT holds one extra cycle after the commit so
  // that wr_done is visible before cmd_ready comes back.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_INIT: begin
        if (w_initLast) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_nextState = i_cmd_write ? ST_WR_DATA : ST_RD_WAIT;
        end
      end
      ST_WR_DATA: begin
        if (w_lastBeatIn) begin
          w_nextState = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (r_wrDone) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (w_cntZero) begin
          w_nextState = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (r_beat == LAST_BEAT) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_INIT;
      end
    endcase
  end

  // Output decode. Read data comes straight from the addressed line so
  // that an asynchronous reset forces rdata_valid and rdata low at once.
  always_comb begin
    o_cmd_ready   = 1'b0;
    o_wdata_ready = 1'b0;
    o_rdata_valid = 1'b0;
    o_rdata       = '0;
    o_rdata_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
      end
      ST_WR_DATA: begin
        o_wdata_ready = 1'b1;
      end
      ST_RD_DATA: begin
        o_rdata_valid = 1'b1;
        o_rdata       = w_readLine[int'(r_beat) * BUS_BITS +: BUS_BITS];
        o_rdata_last  = (r_beat == LAST_BEAT);
      end
      default: begin
        o_cmd_ready = 1'b0;
      end
    endcase
  end

  assign o_wr_done   = r_wrDone;
  assign o_init_done = r_initDone;

  // Datapath registers: fill pointer and LFSR, latched command address,
  // beat index shared by the write and read bursts, latency counter and
  // the write-line buffer. The counter is loaded with LATENCY-1 on the
  // edge that starts the wait, so the wait ends LATENCY edges later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_cnt      <= '0;
      r_beat     <= '0;
      r_initLine <= '0;
      r_initByte <= '0;
      r_lfsr     <= SEED;
      r_wbuf     <= '0;
      r_wrDone   <= 1'b0;
      r_initDone <= 1'b0;
    end else begin
      r_wrDone <= w_commit;
      case (r_state)
        ST_INIT: begin
          r_lfsr <= w_lfsrNext;
          if (r_initByte == LAST_BYTE) begin
            r_initByte <= '0;
            r_initLine <= r_initLine + 1'b1;
          end else begin
            r_initByte <= r_initByte + 1'b1;
          end
          if (w_initLast) begin
            r_initDone <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_cmdFire) begin
            r_addr <= i_cmd_addr;
            r_beat <= '0;
            r_cnt  <= CNT_LOAD;
          end
        end
        ST_WR_DATA: begin
          if (w_beatFire) begin
            r_wbuf[int'(r_beat) * BUS_BITS +: BUS_BITS] <= i_wdata;
            r_beat <= r_beat + 1'b1;
          end
          if (w_lastBeatIn) begin
            r_cnt <= CNT_LOAD;
          end
        end
        ST_WR_WAIT: begin
          if (!w_cntZero) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (!w_cntZero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_beat <= '0;
          end
        end
        ST_RD_DATA: begin
          r_beat <= r_beat + 1'b1;
        end
        default: begin
          r_beat <= '0;
        end
      endcase
    end
  end

  // Storage writes. The fill pass writes one byte per cycle. A committed
  // write replaces the whole line from the beat buffer in a single cycle,
  // so a read issued right after wr_done already sees the new data.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_initLine][int'(r_initByte) * 8 +: 8] <= r_lfsr[7:0];
    end else if (w_commit) begin
      r_mem[r_addr] <= r_wbuf;
    end
  end

endmodule

// File: tb/tb_mem_ctr_burst.sv
// -----------------------------------------------------------------------------
// tb_mem_ctr_burst
//
// Directed bench for mem_ctr_burst. Three instances run side by side:
//   S : ADDR_W=2, LINE_BYTES=4, BUS_BYTES=2, LATENCY=3, SEED=1 (16-byte fill)
//   W : as S but ADDR_W=3, so that line 5 exists for the write/read-back
//   D : default parameters, used for the long read-latency scenario
// -----------------------------------------------------------------------------
module tb_mem_ctr_burst;

  localparam logic [31:0] SEED_D = 32'd225526;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  logic        sRstN, sCmdValid, sCmdReady, sCmdWrite;
  logic [1:0]  sCmdAddr;
  logic        sWdataValid, sWdataReady, sRdataValid, sRdataLast, sWrDone, sInitDone;
  logic [15:0] sWdata, sRdata;

  logic        wRstN, wCmdValid, wCmdReady, wCmdWrite;
  logic [2:0]  wCmdAddr;
  logic        wWdataValid, wWdataReady, wRdataValid, wRdataLast, wWrDone, wInitDone;
  logic [15:0] wWdata, wRdata;

  logic        dRstN, dCmdValid, dCmdReady, dCmdWrite;
  logic [9:0]  dCmdAddr;
  logic        dWdataValid, dWdataReady, dRdataValid, dRdataLast, dWrDone, dInitDone;
  logic [15:0] dWdata, dRdata;

  int wrDonePulsesS = 0;
  int rdBeatsS      = 0;

  mem_ctr_burst #(.ADDR_W(2), .LINE_BYTES(4), .BUS_BYTES(2), .LATENCY(3), .SEED(32'd1)) dutS (
    .i_clk(clk), .i_rst_n(sRstN), .i_cmd_valid(sCmdValid), .o_cmd_ready(sCmdReady),
    .i_cmd_write(sCmdWrite), .i_cmd_addr(sCmdAddr), .i_wdata_valid(sWdataValid),
    .o_wdata_ready(sWdataReady), .i_wdata(sWdata), .o_rdata_valid(sRdataValid),
    .o_rdata(sRdata), .o_rdata_last(sRdataLast), .o_wr_done(sWrDone), .o_init_done(sInitDone)
  );

  mem_ctr_burst #(.ADDR_W(3), .LINE_BYTES(4), .BUS_BYTES(2), .LATENCY(3), .SEED(32'd1)) dutW (
    .i_clk(clk), .i_rst_n(wRstN), .i_cmd_valid(wCmdValid), .o_cmd_ready(wCmdReady),
    .i_cmd_write(wCmdWrite), .i_cmd_addr(wCmdAddr), .i_wdata_valid(wWdataValid),
    .o_wdata_ready(wWdataReady), .i_wdata(wWdata), .o_rdata_valid(wRdataValid),
    .o_rdata(wRdata), .o_rdata_last(wRdataLast), .o_wr_done(wWrDone), .o_init_done(wInitDone)
  );

  mem_ctr_burst dutD (
    .i_clk(clk), .i_rst_n(dRstN), .i_cmd_valid(dCmdValid), .o_cmd_ready(dCmdReady),
    .i_cmd_write(dCmdWrite), .i_cmd_addr(dCmdAddr), .i_wdata_valid(dWdataValid),
    .o_wdata_ready(dWdataReady), .i_wdata(dWdata), .o_rdata_valid(dRdataValid),
    .o_rdata(dRdata), .o_rdata_last(dRdataLast), .o_wr_done(dWrDone), .o_init_done(dInitDone)
  );

  // Event counters on S, sampled mid-cycle, so tests can prove that no
  // write commit or read beat slipped out across a reset.
  always @(negedge clk) begin
    if (sWrDone === 1'b1) wrDonePulsesS++;
    if (sRdataValid === 1'b1) rdBeatsS++;
  end

  // Fill pattern: byte idx of the store after reset, from the 32-bit
  // Galois right-shift LFSR with taps 0x80200003.
  function automatic logic [7:0] fillByte(input logic [31:0] seed, input int idx);
    logic [31:0] lfsr;
    lfsr = seed;
    for (int n = 0; n < idx; n++) begin
      lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
    end
    return lfsr[7:0];
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    if (sCmdReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_cmd_ready: got %b want 0", sCmdReady); end
    nCompared++;
    if (sWdataReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_wdata_ready: got %b want 0", sWdataReady); end
    nCompared++;
    if (sRdataValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rdata_valid: got %b want 0", sRdataValid); end
    nCompared++;
    if (sRdata !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h want 0000", sRdata); end
    nCompared++;
    if (sRdataLast !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rdata_last: got %b want 0", sRdataLast); end
    nCompared++;
    if (sWrDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_wr_done: got %b want 0", sWrDone); end
    nCompared++;
    if (sInitDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_init_done: got %b want 0", sInitDone); end
    nCompared++;
  endtask

  // Command held from reset release; also covers the fill check read.
  task automatic test_cmd_during_init();
    int early;
    early = 0;
    sCmdValid = 1'b1;
    sCmdWrite = 1'b0;
    sCmdAddr  = 2'd0;
    sRstN     = 1'b1;
    wRstN     = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      if (sInitDone !== 1'b0 || sCmdReady !== 1'b0) early++;
    end
    if (early !== 0) begin nMismatched++; $display("[TB] FAIL init_early: got %0d early cycles want 0", early); end
    nCompared++;
    step(1);
    if (sInitDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL init_done_16: got %b want 1", sInitDone); end
    nCompared++;
    if (sCmdReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL init_cmd_ready: got %b want 1", sCmdReady); end
    nCompared++;
    step(1);
    sCmdValid = 1'b0;
    if (sCmdReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL cmd_ready_fall: got %b want 0", sCmdReady); end
    nCompared++;
    step(2);
    if (sRdataValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL fill_early_beat: got %b want 0", sRdataValid); end
    nCompared++;
    step(1);
    if (sRdataValid !== 1'b1 || sRdata !== 16'h0301 || sRdataLast !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL fill_beat0: got v=%b d=%h l=%b want v=1 d=0301 l=0", sRdataValid, sRdata, sRdataLast);
    end
    nCompared++;
    step(1);
    if (sRdataValid !== 1'b1 || sRdata !== 16'h0102 || sRdataLast !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL fill_beat1: got v=%b d=%h l=%b want v=1 d=0102 l=1", sRdataValid, sRdata, sRdataLast);
    end
    nCompared++;
    step(1);
    if (sRdataValid !== 1'b0 || sRdata !== 16'h0000 || sCmdReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL fill_read_end: got v=%b d=%h rdy=%b want v=0 d=0000 rdy=1", sRdataValid, sRdata, sCmdReady);
    end
    nCompared++;
  endtask

  task automatic test_write_readback();
    int n;
    n = 0;
    while (wInitDone !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    if (wInitDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL wr_init_timeout: got %b want 1", wInitDone); end
    nCompared++;
    // A beat offered while idle must be ignored.
    wWdataValid = 1'b1;
    wWdata      = 16'hDEAD;
    step(1);
    wWdataValid = 1'b0;
    if (wWdataReady !== 1'b0 || wCmdReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL wr_idle_beat: got wrdy=%b crdy=%b want wrdy=0 crdy=1", wWdataReady, wCmdReady);
    end
    nCompared++;
    wCmdValid = 1'b1;
    wCmdWrite = 1'b1;
    wCmdAddr  = 3'd5;
    step(1);
    wCmdValid = 1'b0;
    wCmdWrite = 1'b0;
    if (wWdataReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL wr_data_ready: got %b want 1", wWdataReady); end
    nCompared++;
    wWdataValid = 1'b1;
    wWdata      = 16'h1111;
    step(1);
    wWdataValid = 1'b0;
    step(1);
    wWdataValid = 1'b1;
    wWdata      = 16'h2222;
    step(1);
    wWdataValid = 1'b0;
    if (wWdataReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL wr_ready_after_last: got %b want 0", wWdataReady); end
    nCompared++;
    step(2);
    if (wWrDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL wr_done_early: got %b want 0", wWrDone); end
    nCompared++;
    step(1);
    if (wWrDone !== 1'b1 || wCmdReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL wr_done_pulse: got done=%b rdy=%b want done=1 rdy=0", wWrDone, wCmdReady);
    end
    nCompared++;
    step(1);
    if (wWrDone !== 1'b0 || wCmdReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL wr_done_end: got done=%b rdy=%b want done=0 rdy=1", wWrDone, wCmdReady);
    end
    nCompared++;
    wCmdValid = 1'b1;
    wCmdAddr  = 3'd5;
    step(1);
    wCmdValid = 1'b0;
    step(3);
    if (wRdataValid !== 1'b1 || wRdata !== 16'h1111 || wRdataLast !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rb_beat0: got v=%b d=%h l=%b want v=1 d=1111 l=0", wRdataValid, wRdata, wRdataLast);
    end
    nCompared++;
    step(1);
    if (wRdataValid !== 1'b1 || wRdata !== 16'h2222 || wRdataLast !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL rb_beat1: got v=%b d=%h l=%b want v=1 d=2222 l=1", wRdataValid, wRdata, wRdataLast);
    end
    nCompared++;
    step(1);
  endtask

  task automatic test_reset_mid_write();
    int early;
    int pulsesBefore;
    logic [15:0] exp0, exp1;
    early        = 0;
    pulsesBefore = wrDonePulsesS;
    sCmdValid = 1'b1;
    sCmdWrite = 1'b1;
    sCmdAddr  = 2'd2;
    step(1);
    sCmdValid = 1'b0;
    sCmdWrite = 1'b0;
    sWdataValid = 1'b1;
    sWdata      = 16'hAAAA;
    step(1);
    sWdataValid = 1'b0;
    sRstN = 1'b0;
    #1;
    if (sWdataReady !== 1'b0 || sCmdReady !== 1'b0 || sInitDone !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL mw_reset_async: got wrdy=%b crdy=%b init=%b want 0 0 0", sWdataReady, sCmdReady, sInitDone);
    end
    nCompared++;
    step(2);
    sRstN = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      if (sInitDone !== 1'b0) early++;
    end
    if (early !== 0) begin nMismatched++; $display("[TB] FAIL mw_init_early: got %0d early cycles want 0", early); end
    nCompared++;
    step(1);
    if (sInitDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL mw_init_done: got %b want 1", sInitDone); end
    nCompared++;
    exp0 = {fillByte(32'd1, 9), fillByte(32'd1, 8)};
    exp1 = {fillByte(32'd1, 11), fillByte(32'd1, 10)};
    sCmdValid = 1'b1;
    sCmdAddr  = 2'd2;
    step(1);
    sCmdValid = 1'b0;
    step(3);
    if (sRdataValid !== 1'b1 || sRdata !== exp0) begin
      nMismatched++;
      $display("[TB] FAIL mw_line_beat0: got v=%b d=%h want v=1 d=%h", sRdataValid, sRdata, exp0);
    end
    nCompared++;
    step(1);
    if (sRdataValid !== 1'b1 || sRdata !== exp1) begin
      nMismatched++;
      $display("[TB] FAIL mw_line_beat1: got v=%b d=%h want v=1 d=%h", sRdataValid, sRdata, exp1);
    end
    nCompared++;
    step(1);
    if (wrDonePulsesS - pulsesBefore !== 0) begin
      nMismatched++;
      $display("[TB] FAIL mw_no_wr_done: got %0d pulses want 0", wrDonePulsesS - pulsesBefore);
    end
    nCompared++;
  endtask

  task automatic test_reset_mid_read();
    int n;
    int beatsBefore;
    n = 0;
    sCmdValid = 1'b1;
    sCmdWrite = 1'b0;
    sCmdAddr  = 2'd1;
    step(1);
    sCmdValid = 1'b0;
    while (sRdataValid !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    if (sRdataValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL mr_beat_timeout: got %b want 1", sRdataValid); end
    nCompared++;
    sRstN = 1'b0;
    #1;
    beatsBefore = rdBeatsS;
    if (sRdataValid !== 1'b0 || sRdata !== 16'h0000 || sRdataLast !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL mr_reset_async: got v=%b d=%h l=%b want 0 0000 0", sRdataValid, sRdata, sRdataLast);
    end
    nCompared++;
    step(2);
    sRstN = 1'b1;
    step(16);
    if (sInitDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL mr_init_done: got %b want 1", sInitDone); end
    nCompared++;
    step(6);
    if (rdBeatsS - beatsBefore !== 0) begin
      nMismatched++;
      $display("[TB] FAIL mr_no_beats: got %0d beats want 0", rdBeatsS - beatsBefore);
    end
    nCompared++;
  endtask

  task automatic test_read_latency();
    int n;
    logic        expValid, expLast, expReady;
    logic [15:0] expData;
    n = 0;
    dRstN = 1'b1;
    while (dInitDone !== 1'b1 && n < 17000) begin
      step(1);
      n++;
    end
    if (n !== 16384 || dInitDone !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL lat_init_cycles: got %0d cycles done=%b want 16384 done=1", n, dInitDone);
    end
    nCompared++;
    dCmdValid = 1'b1;
    dCmdWrite = 1'b0;
    dCmdAddr  = 10'd0;
    step(1);
    dCmdValid = 1'b0;
    for (int i = 1; i <= 108; i++) begin
      step(1);
      expValid = (i >= 100) && (i <= 107);
      expLast  = (i == 107);
      expReady = (i == 108);
      expData  = expValid ? {fillByte(SEED_D, 2 * (i - 100) + 1), fillByte(SEED_D, 2 * (i - 100))} : 16'h0000;
      if (dRdataValid !== expValid || dRdataLast !== expLast || dCmdReady !== expReady || dRdata !== expData) begin
        nMismatched++;
        $display("[TB] FAIL lat_cycle_%0d: got v=%b l=%b rdy=%b d=%h want v=%b l=%b rdy=%b d=%h",
                 i, dRdataValid, dRdataLast, dCmdReady, dRdata, expValid, expLast, expReady, expData);
      end
      nCompared++;
    end
  endtask

  initial begin
    sRstN = 1'b0; sCmdValid = 1'b0; sCmdWrite = 1'b0; sCmdAddr = '0; sWdataValid = 1'b0; sWdata = '0;
    wRstN = 1'b0; wCmdValid = 1'b0; wCmdWrite = 1'b0; wCmdAddr = '0; wWdataValid = 1'b0; wWdata = '0;
    dRstN = 1'b0; dCmdValid = 1'b0; dCmdWrite = 1'b0; dCmdAddr = '0; dWdataValid = 1'b0; dWdata = '0;
    step(3);
    test_reset();
    test_cmd_during_init();
    test_write_readback();
    test_reset_mid_write();
    test_reset_mid_read();
    test_read_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
